// File: rtl/cache_pkg.sv
// Shared geometry, address-field layout and FSM encoding for the
// direct-mapped read-only cache.
package cache_pkg;
  localparam int SETS    = 1024;
  localparam int TAG_W   = 3;
  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int OFF_W   = 2;
  localparam int IDX_W   = $clog2(SETS);
  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;

  // Word address = {tag, index, offset}.
  localparam int OFF_LSB = 0;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_FETCH   = 2'd2,
    S_RESPOND = 2'd3
  } state_e;
endpackage

// File: rtl/cache_array.sv
// Line storage: valid bits (synchronously clearable), tags and 4-word lines.
// Reads are combinational; a fill writes a whole line in one edge.
module cache_array
  import cache_pkg::*;
#(
  parameter int SETS   = cache_pkg::SETS,
  parameter int TAG_W  = cache_pkg::TAG_W,
  parameter int WORD_W = cache_pkg::WORD_W
) (
  input  logic                           clk,
  input  logic                           clr_i,
  input  logic [$clog2(SETS)-1:0]        idx_i,
  output logic                           vld_o,
  output logic [TAG_W-1:0]               tag_o,
  output logic [WORDS-1:0][WORD_W-1:0]   line_o,
  input  logic                           we_i,
  input  logic [TAG_W-1:0]               wr_tag_i,
  input  logic [WORDS-1:0][WORD_W-1:0]   wr_line_i
);
  logic [SETS-1:0]                 vld_q;
  logic [TAG_W-1:0]                tag_q  [SETS];
  logic [WORDS-1:0][WORD_W-1:0]    data_q [SETS];

  always_ff @(posedge clk) begin
    if (clr_i)     vld_q        <= '0;
    else if (we_i) vld_q[idx_i] <= 1'b1;
  end

  // Tag/data carry no reset; the valid bit alone guards them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_line_i;
    end
  end

  assign vld_o  = vld_q[idx_i];
  assign tag_o  = tag_q[idx_i];
  assign line_o = data_q[idx_i];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read-only cache controller: IDLE/COMPARE/FETCH/RESPOND FSM,
// block fill from main memory and saturating hit/access statistics.
module cache_controller
  import cache_pkg::*;
#(
  parameter int SETS   = cache_pkg::SETS,
  parameter int TAG_W  = cache_pkg::TAG_W,
  parameter int WORD_W = cache_pkg::WORD_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cpu_req,
  input  logic [TAG_W+$clog2(SETS)+OFF_W-1:0]  cpu_addr,
  output logic                                 cpu_ready,
  output logic                                 cpu_done,
  output logic [WORD_W-1:0]                    cpu_data,
  output logic                                 cpu_hit,
  output logic                                 mem_req,
  output logic [TAG_W+$clog2(SETS)+OFF_W-1:0]  mem_addr,
  input  logic                                 mem_ready,
  input  logic [WORD_W-1:0]                    mem_data1,
  input  logic [WORD_W-1:0]                    mem_data2,
  input  logic [WORD_W-1:0]                    mem_data3,
  input  logic [WORD_W-1:0]                    mem_data4,
  output logic [15:0]                          hit_count,
  output logic [15:0]                          access_count
);
  localparam int IW = $clog2(SETS);
  localparam int AW = TAG_W + IW + OFF_W;
  localparam int TL = IDX_LSB + IW;

  state_e                        state_q;
  logic [AW-1:0]                 addr_q;
  logic [WORD_W-1:0]             fill_q;
  logic [15:0]                   acc_q, acc_d, hit_q, hit_d;

  logic                          arr_vld, hit, we;
  logic [TAG_W-1:0]              arr_tag;
  logic [WORDS-1:0][WORD_W-1:0]  arr_line, mem_line;
  logic [IW-1:0]                 idx;
  logic [TAG_W-1:0]              tag;
  logic [OFF_W-1:0]              off;

  assign idx      = addr_q[TL-1:IDX_LSB];
  assign tag      = addr_q[AW-1:TL];
  assign off      = addr_q[IDX_LSB-1:OFF_LSB];
  assign mem_line = {mem_data4, mem_data3, mem_data2, mem_data1};
  assign hit      = arr_vld && (arr_tag == tag);
  // Gated by rst_n so a reset landing in FETCH never commits the fill.
  assign we       = (state_q == S_FETCH) && mem_ready && rst_n;

  cache_array #(.SETS(SETS), .TAG_W(TAG_W), .WORD_W(WORD_W)) u_array (
    .clk       (clk),
    .clr_i     (!rst_n),
    .idx_i     (idx),
    .vld_o     (arr_vld),
    .tag_o     (arr_tag),
    .line_o    (arr_line),
    .we_i      (we),
    .wr_tag_i  (tag),
    .wr_line_i (mem_line)
  );

  assign cpu_ready    = (state_q == S_IDLE);
  assign cpu_hit      = (state_q == S_COMPARE) && hit;
  assign cpu_done     = cpu_hit || (state_q == S_RESPOND);
  assign cpu_data     = cpu_hit ? arr_line[off] :
                        (state_q == S_RESPOND) ? fill_q : '0;
  assign mem_req      = (state_q == S_FETCH);
  assign mem_addr     = {addr_q[AW-1:OFF_W], {OFF_W{1'b0}}};
  assign hit_count    = hit_q;
  assign access_count = acc_q;

  always_comb begin
    acc_d = acc_q;
    hit_d = hit_q;
    if (cpu_done && acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
    if (cpu_hit  && hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      hit_q   <= '0;
    end else begin
      acc_q <= acc_d;
      hit_q <= hit_d;
      case (state_q)
        S_IDLE:    if (cpu_req) begin
                     addr_q  <= cpu_addr;
                     state_q <= S_COMPARE;
                   end
        S_COMPARE: state_q <= hit ? S_IDLE : S_FETCH;
        S_FETCH:   if (mem_ready) begin
                     fill_q  <= mem_line[off];
                     state_q <= S_RESPOND;
                   end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameters: SETS, default 1024, number of cache sets; TAG_W, default 3, tag width; WORD_W, default 32, data word width.
REQ-002 SHALL have port clk, input, 1, the single clock; every flop updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port cpu_req, input, 1, read request from the CPU.
REQ-005 SHALL have port cpu_addr, input, 15, word address: tag [14:12], index [11:2], offset [1:0].
REQ-006 SHALL have port cpu_ready, output, 1, high when the controller can accept a request.
REQ-007 SHALL have port cpu_done, output, 1, one-cycle pulse meaning cpu_data is valid.
REQ-008 SHALL have port cpu_data, output, 32, the requested word.
REQ-009 SHALL have port cpu_hit, output, 1, qualified by cpu_done; 1 on hit, 0 on miss.
REQ-010 SHALL have port mem_req, output, 1, block-fetch request to main memory.
REQ-011 SHALL have port mem_addr, output, 15, block-aligned address {tag, index, 2'b00}.
REQ-012 SHALL have port mem_ready, input, 1, memory block valid this cycle.
REQ-013 SHALL have ports mem_data1..mem_data4, input, 32 each, words at offsets 0..3.
REQ-014 SHALL have ports hit_count and access_count, output, 16 each, statistics counters.

Function
REQ-015 SHALL hold a direct-mapped, read-only store: per set a valid bit, a TAG_W-bit tag and 4 words.
REQ-016 SHALL implement the FSM states IDLE, COMPARE, FETCH and RESPOND; cpu_ready = (state == IDLE).
REQ-017 IDLE: at an edge with cpu_req=1, SHALL latch cpu_addr and go to COMPARE; cpu_addr is ignored at all other times.
REQ-018 COMPARE, hit (valid and tag match): SHALL assert cpu_done=1 and cpu_hit=1 with cpu_data = the stored word[offset] in that same cycle, then return to IDLE.
REQ-019 COMPARE, miss: SHALL go to FETCH.
REQ-020 FETCH: SHALL hold mem_req=1 and mem_addr stable; at an edge with mem_ready=1 it SHALL write all 4 words, set the tag, set valid, capture word[offset], and go to RESPOND.
REQ-021 RESPOND: SHALL assert cpu_done=1 and cpu_hit=0 with cpu_data = the captured word, then return to IDLE.
REQ-022 Latency SHALL be: hit, cpu_done one cycle after the accept edge; miss, cpu_done exactly one cycle after the mem_ready edge.
REQ-023 cpu_req while not in IDLE SHALL be ignored, with no queuing; mem_ready outside FETCH SHALL be ignored.
REQ-024 A miss SHALL evict the resident line unconditionally; no write-back is needed because the store is read-only.
REQ-025 access_count SHALL increment on every cpu_done; hit_count SHALL increment on cpu_done with cpu_hit=1; both SHALL saturate at 16'hFFFF.
REQ-026 When cpu_done=0, cpu_data SHALL be 0.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL set state to IDLE, clear all valid bits, clear both counters, and drive mem_req=0, cpu_done=0, cpu_hit=0 and cpu_data=0.
REQ-028 Reset in FETCH SHALL abort the fill: mem_req=0 in the next cycle and no array write.
REQ-029 Tag and data arrays SHALL NOT need reset.

Structure
REQ-030 SETS, TAG_W, WORD_W, the address field positions and the FSM state encoding SHALL live in a shared package, cache_pkg.
REQ-031 The storage SHALL be one sub-module, cache_array: combinational read, synchronous write of a whole line, and synchronous valid clear.

Verification
REQ-032 After reset, read 0x0005 with memory returning 4,5,6,7 for block 0x0004 -> mem_addr=0x0004, cpu_data=5, cpu_hit=0, access_count=1, hit_count=0.
REQ-033 Then read 0x0006 -> cpu_done one cycle after accept, cpu_data=6, cpu_hit=1, hit_count=1.
REQ-034 Read 0x1005 (tag 1, index 1) then 0x0005 -> both miss, and mem_addr = 0x1004 then 0x0004.
REQ-035 Read 0x7FFF -> mem_addr=0x7FFC, and the set-1023 line fills correctly.
REQ-036 Delay mem_ready 5 cycles while toggling cpu_req and cpu_addr -> mem_addr is stable, the stray requests are ignored, and cpu_done comes exactly one cycle after mem_ready.
REQ-037 Pull rst_n low during FETCH, then re-read 0x0005 -> mem_req=0 next cycle, state IDLE, counters 0, and the re-read misses.
